// File: rtl/wb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_mem_arbiter
// Brief    : Two-master Wishbone arbiter in front of a single DDR bridge slave.
//            Round-robin on ties; optional bus timeout under WB_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_mem_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    m_cyc_i,
    input  logic [1:0]                    m_stb_i,
    input  logic [1:0]                    m_we_i,
    input  logic [2*ADDR_WIDTH-1:0]       m_adr_i,
    input  logic [2*DATA_WIDTH-1:0]       m_dat_i,
    input  logic [2*(DATA_WIDTH/8)-1:0]   m_sel_i,
    input  logic [5:0]                    m_cti_i,
    input  logic [3:0]                    m_bte_i,
    output logic [1:0]                    m_ack_o,
    output logic [1:0]                    m_err_o,
    output logic [1:0]                    m_rty_o,
    output logic [DATA_WIDTH-1:0]         m_dat_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic [ADDR_WIDTH-1:0]         s_adr_o,
    output logic [DATA_WIDTH-1:0]         s_dat_o,
    output logic [DATA_WIDTH/8-1:0]       s_sel_o,
    output logic [2:0]                    s_cti_o,
    output logic [1:0]                    s_bte_o,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    input  logic                          s_rty_i,
    input  logic [DATA_WIDTH-1:0]         s_dat_i
);

    localparam int         c_SEL_W = DATA_WIDTH / 8;
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUS0  = 2'd1;
    localparam logic [1:0] c_BUS1  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic       w_bus0;
    logic       w_bus1;
    logic       w_busy;
    logic       w_owner;
    logic       w_own_cyc;
    logic       w_own_stb;
    logic       w_timeout;
    logic       w_err;

    assign w_bus0    = (r_state == c_BUS0);
    assign w_bus1    = (r_state == c_BUS1);
    assign w_busy    = w_bus0 | w_bus1;
    assign w_owner   = w_bus1;
    assign w_own_cyc = w_owner ? m_cyc_i[1] : m_cyc_i[0];
    assign w_own_stb = w_owner ? m_stb_i[1] : m_stb_i[0];

    // Tie goes to the master that was not served last.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            c_IDLE: begin
                case (m_cyc_i)
                    2'b01:   w_state_nxt = c_BUS0;
                    2'b10:   w_state_nxt = c_BUS1;
                    2'b11:   w_state_nxt = r_last ? c_BUS0 : c_BUS1;
                    default: w_state_nxt = c_IDLE;
                endcase
            end
            c_BUS0: begin
                if (!m_cyc_i[0]) begin
                    w_state_nxt = c_IDLE;
                    w_last_nxt  = 1'b0;
                end
            end
            c_BUS1: begin
                if (!m_cyc_i[1]) begin
                    w_state_nxt = c_IDLE;
                    w_last_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [9:0] c_TMO_MAX = 10'd1023;

    logic [9:0] r_tmo_cnt;

    assign w_timeout = w_busy && (r_tmo_cnt == c_TMO_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= 10'd0;
        end else if (!w_busy || !w_own_cyc || w_timeout || s_ack_i || s_err_i || s_rty_i) begin
            r_tmo_cnt <= 10'd0;
        end else if (w_own_stb) begin
            r_tmo_cnt <= r_tmo_cnt + 10'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Request path: granted master's signals pass straight through.
    assign s_cyc_o = w_busy & w_own_cyc;
    assign s_stb_o = w_busy & w_own_stb & ~w_timeout;
    assign s_we_o  = w_owner ? m_we_i[1] : m_we_i[0];
    assign s_adr_o = w_owner ? m_adr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_adr_i[ADDR_WIDTH-1:0];
    assign s_dat_o = w_owner ? m_dat_i[2*DATA_WIDTH-1:DATA_WIDTH] : m_dat_i[DATA_WIDTH-1:0];
    assign s_sel_o = w_owner ? m_sel_i[2*c_SEL_W-1:c_SEL_W]       : m_sel_i[c_SEL_W-1:0];
    assign s_cti_o = w_owner ? m_cti_i[5:3] : m_cti_i[2:0];
    assign s_bte_o = w_owner ? m_bte_i[3:2] : m_bte_i[1:0];

    // Response path: only the granted master sees terminations.
    assign w_err   = s_err_i | w_timeout;
    assign m_ack_o = {w_bus1 & s_ack_i, w_bus0 & s_ack_i};
    assign m_err_o = {w_bus1 & w_err,   w_bus0 & w_err};
    assign m_rty_o = {w_bus1 & s_rty_i, w_bus0 & s_rty_i};
    assign m_dat_o = s_dat_i;

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
`default_nettype none
// Self-checking bench for wb_mem_arbiter: directed scenarios plus randomized
// two-master traffic checked by a scoreboard against a round-robin model.
module tb_wb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct {
        int            m;
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
    } exp_t;

    logic clk;
    logic rst;

    logic          cyc_v [2];
    logic          stb_v [2];
    logic          we_v  [2];
    logic [AW-1:0] adr_v [2];
    logic [DW-1:0] dat_v [2];
    logic [SW-1:0] sel_v [2];
    logic [2:0]    cti_v [2];

    logic [1:0]      m_cyc_i, m_stb_i, m_we_i;
    logic [2*AW-1:0] m_adr_i;
    logic [2*DW-1:0] m_dat_i;
    logic [2*SW-1:0] m_sel_i;
    logic [5:0]      m_cti_i;
    logic [3:0]      m_bte_i;
    logic [1:0]      m_ack_o, m_err_o, m_rty_o;
    logic [DW-1:0]   m_dat_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [2:0]      s_cti_o;
    logic [1:0]      s_bte_o;
    logic            s_ack_i, s_err_i, s_rty_i;
    logic [DW-1:0]   s_dat_i;

    assign m_cyc_i = {cyc_v[1], cyc_v[0]};
    assign m_stb_i = {stb_v[1], stb_v[0]};
    assign m_we_i  = {we_v[1], we_v[0]};
    assign m_adr_i = {adr_v[1], adr_v[0]};
    assign m_dat_i = {dat_v[1], dat_v[0]};
    assign m_sel_i = {sel_v[1], sel_v[0]};
    assign m_cti_i = {cti_v[1], cti_v[0]};
    assign m_bte_i = 4'b0000;

    wb_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   mode    = 1;  // slave: 0 random ack, 1 ack every strobe, 2 never ack
    bit   mon_en  = 0;
    exp_t q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Slave model: responds at +2 after each rising edge.
    initial begin
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_rty_i = 1'b0;
        s_dat_i = '0;
        forever begin
            @(posedge clk);
            #2;
            s_dat_i = $urandom;
            case (mode)
                0:       s_ack_i = s_cyc_o && s_stb_o && ($urandom_range(0, 2) != 0);
                1:       s_ack_i = s_cyc_o && s_stb_o;
                default: s_ack_i = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor: every completed transfer must match the model's next beat.
    always @(negedge clk) begin
        if (mon_en && s_cyc_o && s_stb_o && s_ack_i) begin
            exp_t e;
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got transfer adr %0h required none", s_adr_o);
            end else begin
                e = q.pop_front();
                check("sb_ack_owner", m_ack_o, (e.m == 1) ? 2'b10 : 2'b01);
                check("sb_adr", s_adr_o, e.adr);
                check("sb_we", s_we_o, e.we);
                check("sb_sel", s_sel_o, e.sel);
                if (e.we) check("sb_wdat", s_dat_o, e.dat);
                else      check("sb_rdat", m_dat_o, s_dat_i);
            end
        end
    end

    task automatic master_run(input int n, input int beats, input logic [AW-1:0] a,
                              input logic w, input logic [DW-1:0] d, input logic [SW-1:0] s);
        int t;
        cyc_v[n] = 1'b1;
        we_v[n]  = w;
        sel_v[n] = s;
        for (int b = 0; b < beats; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                stb_v[n] = 1'b0;
                @(posedge clk);
                #1;
            end
            stb_v[n] = 1'b1;
            adr_v[n] = a + AW'(4 * b);
            dat_v[n] = d + DW'(b);
            cti_v[n] = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
            t = 0;
            while (1) begin
                @(negedge clk);
                if (m_ack_o[n]) break;
                t++;
                if (t > 400) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ack_wait m%0d: got no ack required ack within 400 cycles", n);
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        cyc_v[n] = 1'b0;
        stb_v[n] = 1'b0;
        cti_v[n] = 3'b000;
    endtask

    task automatic push_beats(input int m, input int beats, input logic [AW-1:0] a,
                              input logic w, input logic [DW-1:0] d, input logic [SW-1:0] s);
        exp_t e;
        for (int b = 0; b < beats; b++) begin
            e.m   = m;
            e.adr = a + AW'(4 * b);
            e.we  = w;
            e.dat = d + DW'(b);
            e.sel = s;
            q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle_masters();
        for (int i = 0; i < 2; i++) begin
            cyc_v[i] = 1'b0; stb_v[i] = 1'b0; we_v[i] = 1'b0;
            adr_v[i] = '0;   dat_v[i] = '0;   sel_v[i] = '1; cti_v[i] = 3'b000;
        end
    endtask

    initial begin
        int            err_cnt;
        int            err_idx;
        logic          err_stb;
        int            pat, first, second, mdl_last;
        int            nb [2];
        logic [AW-1:0] ra [2];
        logic          rw [2];
        logic [DW-1:0] rd [2];
        logic [SW-1:0] rs [2];
        logic [31:0]   tmp;

        idle_masters();
        rst = 1'b1;
        cyc_v[0] = 1'b1;
        stb_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cyc", s_cyc_o, 1'b0);
        check("rst_stb", s_stb_o, 1'b0);
        check("rst_ack", m_ack_o, 2'b00);
        check("rst_err", m_err_o, 2'b00);
        check("rst_rty", m_rty_o, 2'b00);
        @(posedge clk);
        #1;
        cyc_v[0] = 1'b0;
        stb_v[0] = 1'b0;
        rst = 1'b0;

        // Single read from master 0, one-cycle arbitration latency.
        @(posedge clk);
        #1;
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; adr_v[0] = 28'h0000100;
        @(negedge clk);
        check("lat_cycle1", s_cyc_o, 1'b0);
        @(negedge clk);
        check("lat_cycle2", s_cyc_o, 1'b1);
        check("rd_adr", s_adr_o, 28'h0000100);
        check("rd_ack", m_ack_o, 2'b01);
        check("rd_dat", m_dat_o, s_dat_i);
        @(posedge clk);
        #1;
        cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
        @(negedge clk);
        check("rd_release", s_cyc_o, 1'b0);
        repeat (2) @(posedge clk);

        // Simultaneous requests after reset: master 0 first, IDLE gap, then master 1.
        do_reset();
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; adr_v[0] = 28'h0000200;
        cyc_v[1] = 1'b1; stb_v[1] = 1'b1; adr_v[1] = 28'h0000300;
        @(negedge clk);
        @(negedge clk);
        check("tie_first_ack", m_ack_o, 2'b01);
        check("tie_first_adr", s_adr_o, 28'h0000200);
        @(posedge clk);
        #1;
        cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
        @(negedge clk);
        check("tie_drop_cyc", s_cyc_o, 1'b0);
        @(negedge clk);
        check("tie_idle_cyc", s_cyc_o, 1'b0);
        check("tie_idle_ack", m_ack_o, 2'b00);
        @(negedge clk);
        check("tie_second_ack", m_ack_o, 2'b10);
        check("tie_second_adr", s_adr_o, 28'h0000300);
        @(posedge clk);
        #1;
        cyc_v[1] = 1'b0; stb_v[1] = 1'b0;
        repeat (2) @(posedge clk);

        // Four-beat burst on master 0; master 1 requests mid-burst, no preemption.
        do_reset();
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; adr_v[0] = 28'h0000400; cti_v[0] = 3'b010;
        @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check("burst_ack", m_ack_o, 2'b01);
            check("burst_adr", s_adr_o, 28'h0000400 + AW'(4 * b));
            check("burst_cti", s_cti_o, (b == 3) ? 3'b111 : 3'b010);
            @(posedge clk);
            #1;
            if (b == 0) begin
                cyc_v[1] = 1'b1; stb_v[1] = 1'b1; adr_v[1] = 28'h0000480;
            end
            adr_v[0] = 28'h0000400 + AW'(4 * (b + 1));
            cti_v[0] = (b == 2) ? 3'b111 : 3'b010;
            if (b == 3) begin
                cyc_v[0] = 1'b0; stb_v[0] = 1'b0; cti_v[0] = 3'b000;
            end
        end
        @(negedge clk);
        check("burst_drop_ack", m_ack_o, 2'b00);
        @(negedge clk);
        @(negedge clk);
        check("burst_m1_ack", m_ack_o, 2'b10);
        @(posedge clk);
        #1;
        cyc_v[1] = 1'b0; stb_v[1] = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset during master 1's second burst beat.
        do_reset();
        cyc_v[1] = 1'b1; stb_v[1] = 1'b1; adr_v[1] = 28'h0000500; cti_v[1] = 3'b010;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_beat1", m_ack_o, 2'b10);
        @(posedge clk);
        #1;
        adr_v[1] = 28'h0000504;
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_cyc", s_cyc_o, 1'b0);
        check("rstmid_stb", s_stb_o, 1'b0);
        check("rstmid_ack", m_ack_o, 2'b00);
        @(posedge clk);
        #1;
        cyc_v[1] = 1'b0; stb_v[1] = 1'b0; cti_v[1] = 3'b000;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; adr_v[0] = 28'h0000600;
        cyc_v[1] = 1'b1; stb_v[1] = 1'b1; adr_v[1] = 28'h0000700;
        @(negedge clk);
        check("rstmid_idle", s_cyc_o, 1'b0);
        @(negedge clk);
        check("rstmid_ptr", m_ack_o, 2'b01);
        @(posedge clk);
        #1;
        idle_masters();
        repeat (3) @(posedge clk);

        // Slave never acknowledges: timeout behaviour depends on build option.
        do_reset();
        mode = 2;
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; adr_v[0] = 28'h0000800;
        err_cnt = 0;
        err_idx = -1;
        err_stb = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (m_err_o != 2'b00) begin
                err_cnt++;
                err_idx = i;
                err_stb = s_stb_o;
                check("tmo_err_owner", m_err_o, 2'b01);
            end
        end
        check("tmo_hold_grant", s_cyc_o, 1'b1);
`ifdef WB_ARB_TIMEOUT_EN
        check("tmo_pulse_count", err_cnt, 1);
        check("tmo_pulse_cycle", err_idx, 1024);
        check("tmo_stb_low", err_stb, 1'b0);
`else
        check("tmo_no_pulse", err_cnt, 0);
`endif
        @(posedge clk);
        #1;
        idle_masters();
        mode = 0;
        repeat (3) @(posedge clk);

        // Randomized two-master traffic against the round-robin model.
        do_reset();
        mdl_last = 1;
        mon_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            pat = $urandom_range(1, 3);
            for (int i = 0; i < 2; i++) begin
                nb[i] = $urandom_range(1, 4);
                tmp   = $urandom;
                ra[i] = {tmp[AW-3:0], 2'b00};
                rw[i] = tmp[31];
                rd[i] = $urandom;
                tmp   = $urandom_range(1, 15);
                rs[i] = tmp[SW-1:0];
            end
            if (pat == 3) begin
                first  = (mdl_last == 1) ? 0 : 1;
                second = 1 - first;
                push_beats(first, nb[first], ra[first], rw[first], rd[first], rs[first]);
                push_beats(second, nb[second], ra[second], rw[second], rd[second], rs[second]);
                mdl_last = second;
            end else begin
                first = (pat == 1) ? 0 : 1;
                push_beats(first, nb[first], ra[first], rw[first], rd[first], rs[first]);
                mdl_last = first;
            end
            @(posedge clk);
            #1;
            fork
                begin
                    if (pat != 2) master_run(0, nb[0], ra[0], rw[0], rd[0], rs[0]);
                end
                begin
                    if (pat != 1) master_run(1, nb[1], ra[1], rw[1], rd[1], rs[1]);
                end
            join
            repeat (2) @(posedge clk);
        end
        mon_en = 1'b0;
        check("sb_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
